iob_asym_fifo_ctrl: RTL and testbench

Synchronous FIFO controller with asymmetric write and read widths. It tracks pointers, fill level and flags for a FIFO built on an asymmetric width converter plus external dual-port RAM. It sits directly upstream of the converter, driving its write and read ports. Read data coming back from the converter is forwarded to the consumer together with a valid strobe.

---
 rtl/iob_asym_fifo_ctrl_if.sv | 39 +++
 rtl/iob_asym_fifo_ctrl.sv | 82 ++++++++
 tb/tb_iob_asym_fifo_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/iob_asym_fifo_ctrl_if.sv
// Handshake and converter-facing bus of the asymmetric FIFO controller.
// master = consumer/producer + converter side, slave = controller.
interface iob_asym_fifo_ctrl_if #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int ADDR_W   = 4
);
    localparam int MIN_W    = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int W_ADDR_W = ADDR_W - $clog2(W_DATA_W / MIN_W);
    localparam int R_ADDR_W = ADDR_W - $clog2(R_DATA_W / MIN_W);

    logic                w_en_i;
    logic [W_DATA_W-1:0] w_data_i;
    logic                w_full_o;
    logic                w_ovf_o;
    logic                r_en_i;
    logic [R_DATA_W-1:0] r_data_o;
    logic                r_valid_o;
    logic                r_empty_o;
    logic                r_udf_o;
    logic [ADDR_W:0]     level_o;
    logic                cnv_w_en_o;
    logic [W_ADDR_W-1:0] cnv_w_addr_o;
    logic [W_DATA_W-1:0] cnv_w_data_o;
    logic                cnv_r_en_o;
    logic [R_ADDR_W-1:0] cnv_r_addr_o;
    logic [R_DATA_W-1:0] cnv_r_data_i;

    modport master (
        output w_en_i, w_data_i, r_en_i, cnv_r_data_i,
        input  w_full_o, w_ovf_o, r_data_o, r_valid_o, r_empty_o, r_udf_o, level_o,
               cnv_w_en_o, cnv_w_addr_o, cnv_w_data_o, cnv_r_en_o, cnv_r_addr_o
    );
    modport slave (
        input  w_en_i, w_data_i, r_en_i, cnv_r_data_i,
        output w_full_o, w_ovf_o, r_data_o, r_valid_o, r_empty_o, r_udf_o, level_o,
               cnv_w_en_o, cnv_w_addr_o, cnv_w_data_o, cnv_r_en_o, cnv_r_addr_o
    );
endinterface

// File: rtl/iob_asym_fifo_ctrl.sv
// Pointer/level/flag controller for a FIFO built on an asymmetric width converter
// and external dual-port RAM; level is counted in min-width units.
module iob_asym_fifo_ctrl #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int ADDR_W   = 4
) (
    input logic                clk_i,
    input logic                rst_n_i,
    input logic                cke_i,
    iob_asym_fifo_ctrl_if.slave bus
);
    localparam int MIN_W    = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int W_INCR   = W_DATA_W / MIN_W;
    localparam int R_INCR   = R_DATA_W / MIN_W;
    localparam int W_ADDR_W = ADDR_W - $clog2(W_INCR);
    localparam int R_ADDR_W = ADDR_W - $clog2(R_INCR);

    localparam logic [ADDR_W:0] W_INC_L = (ADDR_W+1)'(W_INCR);
    localparam logic [ADDR_W:0] R_INC_L = (ADDR_W+1)'(R_INCR);
    localparam logic [ADDR_W:0] CAP_L   = (ADDR_W+1)'(1) << ADDR_W;

    logic [W_ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [R_ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                w_full_q, w_full_d;
    logic                r_empty_q, r_empty_d;
    logic                r_valid_q, r_valid_d;
    logic                w_ovf_q, w_ovf_d;
    logic                r_udf_q, r_udf_d;
    logic                w_acc, r_acc;

    // Flags are the registered view of the level, so a same-cycle read never
    // frees room for a write that arrived while full.
    always_comb begin
        w_acc     = cke_i & bus.w_en_i & ~w_full_q;
        r_acc     = cke_i & bus.r_en_i & ~r_empty_q;
        w_ptr_d   = w_acc ? w_ptr_q + W_ADDR_W'(1) : w_ptr_q;
        r_ptr_d   = r_acc ? r_ptr_q + R_ADDR_W'(1) : r_ptr_q;
        level_d   = level_q + (w_acc ? W_INC_L : '0) - (r_acc ? R_INC_L : '0);
        w_full_d  = (CAP_L - level_d) < W_INC_L;
        r_empty_d = level_d < R_INC_L;
        r_valid_d = r_acc;
        w_ovf_d   = bus.w_en_i & w_full_q;
        r_udf_d   = bus.r_en_i & r_empty_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            level_q   <= '0;
            w_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
            r_valid_q <= 1'b0;
            w_ovf_q   <= 1'b0;
            r_udf_q   <= 1'b0;
        end else if (cke_i) begin
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            level_q   <= level_d;
            w_full_q  <= w_full_d;
            r_empty_q <= r_empty_d;
            r_valid_q <= r_valid_d;
            w_ovf_q   <= w_ovf_d;
            r_udf_q   <= r_udf_d;
        end
    end

    assign bus.cnv_w_en_o   = w_acc;
    assign bus.cnv_w_addr_o = w_ptr_q;
    assign bus.cnv_w_data_o = bus.w_data_i;
    assign bus.cnv_r_en_o   = r_acc;
    assign bus.cnv_r_addr_o = r_ptr_q;
    assign bus.r_data_o     = bus.cnv_r_data_i;
    assign bus.r_valid_o    = r_valid_q;
    assign bus.w_full_o     = w_full_q;
    assign bus.r_empty_o    = r_empty_q;
    assign bus.w_ovf_o      = w_ovf_q;
    assign bus.r_udf_o      = r_udf_q;
    assign bus.level_o      = level_q;
endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Directed bench for iob_asym_fifo_ctrl (8-bit write, 32-bit read, 16-byte capacity)
// with a converter/RAM model and a read-data scoreboard.
module tb_iob_asym_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic cke;

    iob_asym_fifo_ctrl_if #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) bus ();
    iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] sb[$];
    logic [7:0]  bytes[$];
    logic [3:0]  wptr;
    logic [1:0]  rptr;
    logic [7:0]  mem[16];

    // Converter + RAM model: byte writes, 32-bit little-endian reads, 1-cycle latency.
    always @(posedge clk) begin
        if (bus.cnv_w_en_o) mem[bus.cnv_w_addr_o] <= bus.cnv_w_data_o;
        if (bus.cnv_r_en_o)
            bus.cnv_r_data_i <= {mem[{bus.cnv_r_addr_o, 2'd3}], mem[{bus.cnv_r_addr_o, 2'd2}],
                                 mem[{bus.cnv_r_addr_o, 2'd1}], mem[{bus.cnv_r_addr_o, 2'd0}]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every r_valid_o must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (bus.r_valid_o === 1'b1) begin
            if (sb.size() == 0) chk("spurious_r_valid", {31'b0, bus.r_valid_o}, 32'd0);
            else chk("r_data", bus.r_data_o, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pop_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = bytes.pop_front();
        return w;
    endfunction

    task automatic wr(input logic [7:0] d, input bit acc);
        bus.w_en_i = 1'b1; bus.w_data_i = d;
        @(negedge clk);
        chk("cnv_w_en", {31'b0, bus.cnv_w_en_o}, {31'b0, acc});
        if (acc) begin
            chk("cnv_w_addr", {28'b0, bus.cnv_w_addr_o}, {28'b0, wptr});
            chk("cnv_w_data", {24'b0, bus.cnv_w_data_o}, {24'b0, d});
            bytes.push_back(d);
            wptr = wptr + 4'd1;
        end
        tick();
        bus.w_en_i = 1'b0;
    endtask

    task automatic rd(input bit acc, input logic [31:0] exp);
        bus.r_en_i = 1'b1;
        @(negedge clk);
        chk("cnv_r_en", {31'b0, bus.cnv_r_en_o}, {31'b0, acc});
        if (acc) begin
            chk("cnv_r_addr", {30'b0, bus.cnv_r_addr_o}, {30'b0, rptr});
            sb.push_back(exp);
            rptr = rptr + 2'd1;
        end
        tick();
        bus.r_en_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cke = 1'b1;
        bus.w_en_i = 1'b0; bus.w_data_i = '0; bus.r_en_i = 1'b0;
        wptr = '0; rptr = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_level", {27'b0, bus.level_o}, 32'd0);
        chk("rst_empty", {31'b0, bus.r_empty_o}, 32'd1);
        chk("rst_full", {31'b0, bus.w_full_o}, 32'd0);
        chk("rst_cnv_w_en", {31'b0, bus.cnv_w_en_o}, 32'd0);
        chk("rst_cnv_r_en", {31'b0, bus.cnv_r_en_o}, 32'd0);
        chk("rst_r_valid", {31'b0, bus.r_valid_o}, 32'd0);

        // Basic write of 3 then 4 bytes, single word read
        wr(8'h11, 1); wr(8'h22, 1); wr(8'h33, 1);
        chk("lvl3", {27'b0, bus.level_o}, 32'd3);
        chk("lvl3_empty", {31'b0, bus.r_empty_o}, 32'd1);
        wr(8'h44, 1);
        chk("lvl4", {27'b0, bus.level_o}, 32'd4);
        chk("lvl4_empty", {31'b0, bus.r_empty_o}, 32'd0);
        rd(1, 32'h4433_2211);
        bytes.delete();
        chk("lvl0_after_rd", {27'b0, bus.level_o}, 32'd0);
        chk("empty_after_rd", {31'b0, bus.r_empty_o}, 32'd1);

        // Fill, then overflow attempt
        for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i), 1);
        chk("full_level", {27'b0, bus.level_o}, 32'd16);
        chk("full_flag", {31'b0, bus.w_full_o}, 32'd1);
        wr(8'hFF, 0);
        chk("ovf_pulse", {31'b0, bus.w_ovf_o}, 32'd1);
        chk("ovf_level", {27'b0, bus.level_o}, 32'd16);
        tick();
        chk("ovf_once", {31'b0, bus.w_ovf_o}, 32'd0);

        // Simultaneous read + write while full
        bus.w_en_i = 1'b1; bus.w_data_i = 8'hEE; bus.r_en_i = 1'b1;
        @(negedge clk);
        chk("sim_cnv_r_en", {31'b0, bus.cnv_r_en_o}, 32'd1);
        chk("sim_cnv_w_en", {31'b0, bus.cnv_w_en_o}, 32'd0);
        chk("sim_r_addr", {30'b0, bus.cnv_r_addr_o}, {30'b0, rptr});
        sb.push_back(pop_word());
        rptr = rptr + 2'd1;
        tick();
        bus.w_en_i = 1'b0; bus.r_en_i = 1'b0;
        chk("sim_level", {27'b0, bus.level_o}, 32'd12);
        chk("sim_full", {31'b0, bus.w_full_o}, 32'd0);
        chk("sim_ovf", {31'b0, bus.w_ovf_o}, 32'd1);

        for (int i = 0; i < 3; i++) rd(1, pop_word());
        chk("drain_level", {27'b0, bus.level_o}, 32'd0);

        // Underflow
        rd(0, 32'd0);
        chk("udf_pulse", {31'b0, bus.r_udf_o}, 32'd1);
        tick();
        chk("udf_once", {31'b0, bus.r_udf_o}, 32'd0);

        // Wrap: 40 writes, 10 reads interleaved
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) wr(8'(k * 16 + j + 1), 1);
            rd(1, pop_word());
        end
        chk("wrap_level", {27'b0, bus.level_o}, 32'd0);

        // Reset with 8 bytes stored and a read issued in the reset cycle
        for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i), 1);
        chk("pre_rst_level", {27'b0, bus.level_o}, 32'd8);
        bus.r_en_i = 1'b1; rst_n = 1'b0;
        tick();
        bus.r_en_i = 1'b0; rst_n = 1'b1;
        bytes.delete(); wptr = '0; rptr = '0;
        chk("mid_rst_level", {27'b0, bus.level_o}, 32'd0);
        chk("mid_rst_empty", {31'b0, bus.r_empty_o}, 32'd1);
        chk("mid_rst_r_valid", {31'b0, bus.r_valid_o}, 32'd0);
        tick();

        // Clock enable low freezes state
        wr(8'h01, 1); wr(8'h02, 1);
        cke = 1'b0; bus.w_en_i = 1'b1; bus.w_data_i = 8'h55;
        @(negedge clk);
        chk("cke_cnv_w_en", {31'b0, bus.cnv_w_en_o}, 32'd0);
        tick();
        chk("cke_level", {27'b0, bus.level_o}, 32'd2);
        chk("cke_w_ptr", {28'b0, bus.cnv_w_addr_o}, {28'b0, wptr});
        bus.w_en_i = 1'b0; cke = 1'b1;
        tick(); tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
